// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and constants for the instruction-memory port arbiter
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Requester ids, also used as bit positions in the one-hot winner vector
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LOAD  = 1'b1;

  // RISC-V addi x0,x0,0, handy as filler data
  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with loader lock and fetch starvation guard
module rr_arb2
  import imem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       f_req,
  input  logic       f_pend,
  input  logic       l_req,
  input  logic       l_lock,
  input  logic       take,
  output logic [1:0] win
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          last_load_q;
  logic [CW-1:0] starve_q;

  // Pick the winner: alternate on contention, a locked loader keeps the port until fetch has starved long enough
  always_comb begin
    win = 2'b00;
    if (f_req && l_req) begin
      if (last_load_q && !(l_lock && (starve_q != LIMIT))) begin
        win[REQ_FETCH] = 1'b1;
      end else begin
        win[REQ_LOAD] = 1'b1;
      end
    end else if (f_req) begin
      win[REQ_FETCH] = 1'b1;
    end else if (l_req) begin
      win[REQ_LOAD] = 1'b1;
    end
  end

  // Remember the last grant and count loader grants taken while a fetch was waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_load_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      if (take) begin
        last_load_q <= win[REQ_LOAD];
      end
      if (take && win[REQ_LOAD] && f_pend) begin
        if (starve_q != LIMIT) begin
          starve_q <= starve_q + 1'b1;
        end
      end else if ((take && win[REQ_FETCH]) || !f_pend) begin
        starve_q <= '0;
      end
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares the instruction memory port between fetch and the loader/debug port
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic                  f_kill,
  output logic                  f_gnt,
  output logic                  f_rsp_valid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  input  logic                  l_lock,
  output logic                  l_gnt,
  output logic                  l_rsp_valid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  arb_state_e            state_q, state_d;
  logic [1:0]            win;
  logic                  take;
  logic                  f_req_eff;
  logic                  owner_q;
  logic                  we_q;
  logic                  killed_q;
  logic [2:0]            wait_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] f_rdata_q;
  logic [DATA_WIDTH-1:0] l_rdata_q;

  // A flushed fetch may not win arbitration in the cycle of the flush
  assign f_req_eff = f_req & ~f_kill;

  rr_arb2 #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_rr_arb2 (
    .clk    (clk),
    .reset_n(reset_n),
    .f_req  (f_req_eff),
    .f_pend (f_req),
    .l_req  (l_req),
    .l_lock (l_lock),
    .take   (take),
    .win    (win)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencing, grants, memory strobe and response pulses
  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    f_gnt       = 1'b0;
    l_gnt       = 1'b0;
    mem_valid   = 1'b0;
    f_rsp_valid = 1'b0;
    l_rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset_n) begin
          f_gnt = win[REQ_FETCH];
          l_gnt = win[REQ_LOAD];
          take  = |win;
          if (take) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_valid = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        f_rsp_valid = (owner_q == REQ_FETCH) && !killed_q && !f_kill;
        l_rsp_valid = (owner_q == REQ_LOAD);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch on accept, latency countdown, flush tracking and read data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= REQ_FETCH;
      we_q       <= 1'b0;
      killed_q   <= 1'b0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            owner_q  <= win[REQ_LOAD];
            we_q     <= win[REQ_LOAD] & l_we;
            addr_q   <= win[REQ_LOAD] ? l_addr : f_addr;
            killed_q <= 1'b0;
            if (win[REQ_LOAD]) begin
              wdata_q <= l_wdata;
            end
          end
        end
        ISSUE: begin
          wait_cnt_q <= LAT;
          if (f_kill) begin
            killed_q <= 1'b1;
          end
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q - 3'd1;
          if (f_kill) begin
            killed_q <= 1'b1;
          end
          if (wait_cnt_q == 3'd1) begin
            if (owner_q == REQ_LOAD) begin
              l_rdata_q <= we_q ? '0 : mem_rdata;
            end else begin
              f_rdata_q <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = mem_valid & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign f_rdata   = f_rdata_q;
  assign l_rdata   = l_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - randomized scoreboard bench for imem_port_arbiter
module tb_imem_port_arbiter;
  import imem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 4;
  localparam int SLIM = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          f_req, f_kill, f_gnt, f_rsp_valid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          l_req, l_we, l_lock, l_gnt, l_rsp_valid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          mem_valid, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill), .f_gnt(f_gnt),
    .f_rsp_valid(f_rsp_valid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rsp_valid(l_rsp_valid), .l_rdata(l_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;
  typedef struct { int gcyc; int due; logic owner; logic [DW-1:0] data; } rsp_exp_t;

  mem_exp_t      mem_q[$];
  rsp_exp_t      rsp_q[$];
  bit            seq_q[$];
  bit            cur_killed;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];
  logic [DW-1:0] phys_mem [logic [AW-1:0]];
  bit            m_last_load;
  int            m_starve;
  int            free_cyc;
  bit            f_auto, l_auto;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = '0;
    a[8:2] = 7'($urandom_range(0, 127));
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: command seen in cycle c returns its data throughout cycle c+LAT, junk otherwise
  logic [DW-1:0] dl [1:LAT];
  logic [DW-1:0] cap;
  assign mem_rdata = dl[LAT];
  always @(negedge clk) begin
    if (mem_valid && mem_we) begin
      phys_mem[mem_addr] = mem_wdata;
      cap = $urandom;
    end else if (mem_valid) begin
      cap = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : init_word(mem_addr);
    end else begin
      cap = $urandom;
    end
  end
  always @(posedge clk) begin
    #1;
    for (int i = LAT; i > 1; i--) dl[i] = dl[i-1];
    dl[1] = cap;
  end

  // One cycle of the reference model: predict the grant, queue the expected command and response
  task automatic tick();
    bit idle, fe, ef, el, gf, gl;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    mem_exp_t me;
    rsp_exp_t re;
    @(negedge clk);
    idle = (cyc > free_cyc);
    fe = f_req && !f_kill;
    ef = 1'b0;
    el = 1'b0;
    if (idle) begin
      if (fe && l_req) begin
        if (m_last_load && !(l_lock && m_starve < SLIM)) ef = 1'b1;
        else el = 1'b1;
      end else if (fe) ef = 1'b1;
      else if (l_req) el = 1'b1;
    end
    gf = f_gnt;
    gl = l_gnt;
    chk("f_gnt", gf, ef);
    chk("l_gnt", gl, el);
    if (!idle && f_kill) cur_killed = 1'b1;
    if (el && f_req) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
    else if (ef || !f_req) m_starve = 0;
    if (ef || el) begin
      m_last_load = el;
      a = el ? l_addr : f_addr;
      if (el && l_we) begin
        d = '0;
        ref_mem[a] = l_wdata;
      end else begin
        d = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
      end
      me.cyc = cyc + 1; me.we = el && l_we; me.addr = a; me.wdata = l_wdata;
      mem_q.push_back(me);
      re.gcyc = cyc; re.due = cyc + LAT + 2; re.owner = el; re.data = d;
      rsp_q.push_back(re);
      cur_killed = 1'b0;
      free_cyc = cyc + LAT + 2;
    end
    if (gl) seq_q.push_back(1'b1);
    else if (gf) seq_q.push_back(1'b0);
    @(posedge clk);
    #1;
    if (gf) begin
      if (f_auto) f_addr = rnd_addr();
      else f_req = 1'b0;
    end
    if (gl) begin
      if (l_auto) begin
        l_addr = rnd_addr();
        l_wdata = $urandom;
      end else l_req = 1'b0;
    end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300 && (f_req || l_req || cyc <= free_cyc); i++) tick();
    if (i == 300) chk("drain_timeout", 0, 1);
  endtask

  task automatic run_grants(input int n);
    int i;
    for (i = 0; i < 400 && seq_q.size() < n; i++) tick();
    if (seq_q.size() < n) chk("grant_count", seq_q.size(), n);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_f_gnt"}, f_gnt, 0);
    chk({tag, "_l_gnt"}, l_gnt, 0);
    chk({tag, "_f_rsp_valid"}, f_rsp_valid, 0);
    chk({tag, "_l_rsp_valid"}, l_rsp_valid, 0);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_f_rdata"}, f_rdata, 0);
    chk({tag, "_l_rdata"}, l_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: compares memory commands and responses against the scoreboard queues
  initial begin
    bit eb, ev, due, vf, vl;
    mem_exp_t m;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        eb = (rsp_q.size() > 0) && (rsp_q[0].gcyc < cyc);
        chk("busy", busy, eb);
        while (mem_q.size() > 0 && mem_q[0].cyc < cyc) void'(mem_q.pop_front());
        ev = (mem_q.size() > 0) && (mem_q[0].cyc == cyc);
        chk("mem_valid", mem_valid, ev);
        if (ev) begin
          m = mem_q.pop_front();
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end else begin
          chk("mem_we_idle", mem_we, 0);
        end
        due = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
        vf = 1'b0;
        vl = 1'b0;
        if (due) begin
          r = rsp_q.pop_front();
          vf = (r.owner == REQ_FETCH) && !cur_killed;
          vl = (r.owner == REQ_LOAD);
        end
        chk("f_rsp_valid", f_rsp_valid, vf);
        chk("l_rsp_valid", l_rsp_valid, vl);
        if (vf) chk("f_rdata", f_rdata, r.data);
        if (vl) chk("l_rdata", l_rdata, r.data);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    f_req = 1'b1; f_addr = 32'h0; f_kill = 1'b0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4; l_wdata = '0; l_lock = 1'b0;
    ref_mem[32'h40]  = 32'h00500093;
    phys_mem[32'h40] = 32'h00500093;
    for (int i = 1; i <= LAT; i++) dl[i] = NOP_INSN;
    cap = NOP_INSN;
    m_last_load = 1'b0; m_starve = 0; free_cyc = 0; cur_killed = 1'b0;
    f_auto = 1'b0; l_auto = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset");
    reset_n = 1'b1;

    // Contention from reset: loader first, then strict alternation
    f_auto = 1'b1; l_auto = 1'b1;
    seq_q.delete();
    run_grants(6);
    for (int i = 0; i < 6 && i < seq_q.size(); i++) chk("alt_order", seq_q[i], (i % 2 == 0));

    // Locked loader: eight grants, then the starved fetch, then loader again
    l_lock = 1'b1;
    seq_q.delete();
    run_grants(10);
    for (int i = 0; i < 10 && i < seq_q.size(); i++) chk("lock_order", seq_q[i], (i != 8));
    f_auto = 1'b0; l_auto = 1'b0; l_lock = 1'b0;
    drain();

    // Single fetch of a known word
    f_req = 1'b1; f_addr = 32'h40;
    drain();
    chk("fetch_0x40_rdata", f_rdata, 32'h00500093);

    // Loader write then read back
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h100; l_wdata = 32'hDEADBEEF;
    drain();
    chk("write_ack_rdata", l_rdata, 0);
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h100;
    drain();
    chk("readback_rdata", l_rdata, 32'hDEADBEEF);

    // Flush an in-flight fetch during WAIT, then flush while requesting in IDLE
    f_req = 1'b1; f_addr = 32'h80;
    tick();
    tick();
    f_kill = 1'b1;
    tick();
    f_kill = 1'b0;
    drain();
    f_req = 1'b1; f_addr = 32'h84; f_kill = 1'b1;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h88;
    tick();
    f_kill = 1'b0;
    drain();

    // Reset in the middle of WAIT, then a clean restart
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h40;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    f_req = 1'b1; f_addr = 32'h40;
    l_req = 1'b1; l_addr = 32'h100;
    mem_q.delete(); rsp_q.delete();
    m_last_load = 1'b0; m_starve = 0; free_cyc = 0; cur_killed = 1'b0;
    #1;
    reset_check("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seq_q.delete();
    run_grants(2);
    for (int i = 0; i < 2 && i < seq_q.size(); i++) chk("post_reset_order", seq_q[i], (i == 0));
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!f_req && $urandom_range(0, 2) == 0) begin
        f_req = 1'b1; f_addr = rnd_addr();
      end
      if (!l_req && $urandom_range(0, 3) == 0) begin
        l_req = 1'b1; l_we = 1'($urandom_range(0, 1)); l_addr = rnd_addr(); l_wdata = $urandom;
      end
      f_kill = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 29) == 0) l_lock = ~l_lock;
      tick();
    end
    f_kill = 1'b0;
    drain();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
